// File: rtl/register_file_mp.sv
// register_file_mp: multi-port, byte-writable register file with a per-register busy scoreboard.
//   - READ_PORTS asynchronous read ports (data + busy bit).
//   - WRITE_PORTS synchronous write ports. When ports collide, the higher port index wins,
//     and this is decided separately for each byte.
//   - Lock/release scoreboard. Releases clear first, then a lock sets, so a lock and a release
//     of the same register in one cycle hands it over without an error.
//   - Synchronous active-low reset.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_mp #(
    parameter int unsigned WORD        = 16,
    parameter int unsigned REGISTERS   = 8,
    parameter int unsigned READ_PORTS  = 2,
    parameter int unsigned WRITE_PORTS = 2,
    localparam int unsigned BYTES      = WORD / 8,
    localparam int unsigned AW         = $clog2(REGISTERS)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_ni,
    input  logic [WRITE_PORTS-1:0][BYTES-1:0]     wr_be_i,
    input  logic [WRITE_PORTS-1:0][AW-1:0]        wr_addr_i,
    input  logic [WRITE_PORTS-1:0][WORD-1:0]      wr_data_i,
    input  logic [WRITE_PORTS-1:0]                wr_release_i,
    input  logic                                  lock_en_i,
    input  logic [AW-1:0]                         lock_addr_i,
    input  logic [READ_PORTS-1:0][AW-1:0]         rd_addr_i,
    output logic [READ_PORTS-1:0][WORD-1:0]       rd_data_o,
    output logic [READ_PORTS-1:0]                 rd_busy_o,
    output logic                                  lock_err_o,
    output logic [AW:0]                           busy_count_o
);

    logic [REGISTERS-1:0][WORD-1:0] regs_q, regs_d;
    logic [REGISTERS-1:0]           busy_q, busy_d;
    logic [REGISTERS-1:0]           release_mask;
    logic                           lock_err_q, lock_err_d;
    logic [AW:0]                    busy_count_q, busy_count_d;

    // Byte-merge the write ports. Ascending port order lets the higher index override a lower one.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_be_i[p][b]) begin
                    regs_d[wr_addr_i[p]][8*b +: 8] = wr_data_i[p][8*b +: 8];
                end
            end
        end
    end

    // Scoreboard next state: clear released registers, then apply the lock; popcount the result.
    always_comb begin
        release_mask = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (wr_release_i[p]) begin
                release_mask[wr_addr_i[p]] = 1'b1;
            end
        end

        busy_d     = busy_q & ~release_mask;
        lock_err_d = 1'b0;
        if (lock_en_i) begin
            // A register released this cycle is already clear here, so handoff needs no special case.
            if (busy_d[lock_addr_i]) begin
                lock_err_d = 1'b1;
            end else begin
                busy_d[lock_addr_i] = 1'b1;
            end
        end

        busy_count_d = '0;
        for (int r = 0; r < REGISTERS; r++) begin
            busy_count_d = busy_count_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    // State update. Reset drops any write, lock or release presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            regs_q       <= '0;
            busy_q       <= '0;
            lock_err_q   <= 1'b0;
            busy_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            lock_err_q   <= lock_err_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Asynchronous read ports. rd_busy always reflects the stored busy bits.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_data_o[p] = regs_q[rd_addr_i[p]];
            rd_busy_o[p] = busy_q[rd_addr_i[p]];
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < WRITE_PORTS; w++) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (wr_be_i[w][b] && (wr_addr_i[w] == rd_addr_i[p])) begin
                        rd_data_o[p][8*b +: 8] = wr_data_i[w][8*b +: 8];
                    end
                end
            end
`else
            // Without bypass, a write becomes visible only after the posedge that commits it.
`endif
        end
    end

    assign lock_err_o   = lock_err_q;
    assign busy_count_o = busy_count_q;

endmodule
